// File: rtl/dpro_seq.sv
// Signed dot-product sequencer: walks two operand vectors in local RAM and
// accumulates products through the shared ALU, reporting one result per start.
module dpro_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        MUL     = 3'd3,
        ACC     = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_a_q, ptr_a_d;
    logic [ADDR_W-1:0]   ptr_b_q, ptr_b_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   prod_q, prod_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Next-state, datapath updates and ALU drive.
    always_comb begin
        state_d    = state_q;
        ptr_a_d    = ptr_a_q;
        ptr_b_d    = ptr_b_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        acc_d      = acc_q;
        op_a_d     = op_a_q;
        prod_d     = prod_q;
        alu_op     = OP_ADD;
        alu_a      = '0;
        alu_b      = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_a_d = base_a;
                    ptr_b_d = base_b;
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len != '0) ? FETCH_A : FIN;
                end
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: begin
                op_a_d  = mem_rdata;
                state_d = MUL;
            end
            MUL: begin
                // Operand B arrives this cycle and feeds the ALU directly.
                alu_op  = OP_MUL;
                alu_a   = op_a_q;
                alu_b   = mem_rdata;
                prod_d  = alu_out;
                state_d = ACC;
            end
            ACC: begin
                alu_op  = OP_ADD;
                alu_a   = acc_q;
                alu_b   = prod_q;
                acc_d   = alu_out;
                ptr_a_d = ptr_a_q + ADDR_W'(1);
                ptr_b_d = ptr_b_q + ADDR_W'(1);
                cnt_d   = cnt_q + LEN_W'(1);
                state_d = (cnt_d == len_q) ? FIN : FETCH_A;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        mem_rd_d   = (state_d == FETCH_A) || (state_d == FETCH_B);
        mem_addr_d = mem_addr_q;
        if (state_d == FETCH_A) begin
            mem_addr_d = ptr_a_d;
        end else if (state_d == FETCH_B) begin
            mem_addr_d = ptr_b_d;
        end
        result_d   = (state_d == FIN) ? acc_d : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_a_q    <= '0;
            ptr_b_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            op_a_q     <= '0;
            prod_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_a_q    <= ptr_a_d;
            ptr_b_q    <= ptr_b_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            op_a_q     <= op_a_d;
            prod_q     <= prod_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_dpro_seq.sv
// Directed bench for dpro_seq with a behavioural ALU, operand RAM and a
// result scoreboard; every cycle of each run is checked against a timing model.
module tb_dpro_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_a, base_b, len;
    logic        busy, done, mem_rd;
    logic [31:0] result, mem_rdata, alu_a, alu_b, alu_out;
    logic [7:0]  mem_addr;
    logic [2:0]  alu_op;

    logic [31:0] mem [256];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_op == 3'b001) ? alu_a * alu_b : alu_a + alu_b;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    dpro_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
        .len(len), .busy(busy), .done(done), .result(result), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".result"}, result, 32'd0);
        chk({tag, ".mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, ".alu_a"}, alu_a, 32'd0);
        chk({tag, ".alu_b"}, alu_b, 32'd0);
    endtask

    // One operation: start in cycle 0, then check every cycle up to done.
    task automatic run_op(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                          input logic [31:0] exp_res, input bit stray, input int abort_cyc,
                          input string tag);
        int          last;
        bit          seen;
        logic [7:0]  k;
        logic [31:0] exp_pop;
        last = 4 * int'(ln) + 1;
        @(posedge clk); #1;
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        start = 1'b1; base_a = ba; base_b = bb; len = ln;
        sb_q.push_back(exp_res);
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 1; n <= last && !seen; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (n == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero({tag, ".rst_async"});
                void'(sb_q.pop_front());
                @(posedge clk); #1;
                chk({tag, ".rst_nodone"}, 32'(done), 32'd0);
                rst_n = 1'b1;
                return;
            end
            k = 8'((n - 1) / 4);
            if (n < last) begin
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                chk({tag, ".done_early"}, 32'(done), 32'd0);
                chk({tag, ".mem_rd"}, 32'(mem_rd), 32'((n % 4 == 1) || (n % 4 == 2)));
                if (n % 4 == 1) chk({tag, ".addr_a"}, 32'(mem_addr), 32'(8'(ba + k)));
                if (n % 4 == 2) chk({tag, ".addr_b"}, 32'(mem_addr), 32'(8'(bb + k)));
                chk({tag, ".alu_op"}, 32'(alu_op), (n % 4 == 3) ? 32'd1 : 32'd0);
            end else begin
                seen = 1'b1;
                chk({tag, ".done"}, 32'(done), 32'd1);
                chk({tag, ".fin_busy"}, 32'(busy), 32'd1);
                chk({tag, ".fin_mem_rd"}, 32'(mem_rd), 32'd0);
                chk({tag, ".fin_alu_op"}, 32'(alu_op), 32'd0);
                chk({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
                exp_pop = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEADBEEF;
                chk({tag, ".result"}, result, exp_pop);
            end
            start = stray && (n == 3 || n == 13);
        end
    endtask

    logic [31:0] exp_big;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_a = '0; base_b = '0; len = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        mem[8'h10] = 32'd1; mem[8'h11] = 32'd2; mem[8'h12] = 32'd3;
        mem[8'h20] = 32'd4; mem[8'h21] = 32'd5; mem[8'h22] = 32'd6;
        run_op(8'h10, 8'h20, 8'd3, 32'd32, 1'b0, 0, "len3");

        mem[8'h30] = -32'sd2; mem[8'h31] = 32'd7;
        mem[8'h40] = 32'd3;   mem[8'h41] = -32'sd4;
        run_op(8'h30, 8'h40, 8'd2, 32'hFFFF_FFDE, 1'b0, 0, "signed");

        run_op(8'h00, 8'h00, 8'd0, 32'd0, 1'b0, 0, "len0");

        mem[8'hFF] = 32'h0001_0000; mem[8'h00] = 32'h0001_0000;
        mem[8'h7F] = 32'h0001_0000; mem[8'h80] = 32'd1;
        run_op(8'hFF, 8'h7F, 8'd2, 32'h0001_0000, 1'b0, 0, "wrap");

        run_op(8'h10, 8'h20, 8'd3, 32'd32, 1'b1, 0, "stray");
        run_op(8'h30, 8'h40, 8'd2, 32'hFFFF_FFDE, 1'b0, 0, "restart14");

        run_op(8'h10, 8'h20, 8'd3, 32'd32, 1'b0, 6, "abort");
        chk("abort.result_cleared", result, 32'd0);
        run_op(8'h10, 8'h20, 8'd3, 32'd32, 1'b0, 0, "after_rst");

        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 40503) - 32'd3_000_000;
        exp_big = '0;
        for (int i = 0; i < 255; i++) exp_big = exp_big + mem[8'(i)] * mem[8'(i + 128)];
        run_op(8'h00, 8'h80, 8'd255, exp_big, 1'b0, 0, "len255");

        @(posedge clk); #1;
        chk("final_idle", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpro_seq.md
Name: dpro_seq

Overview:
- Multi-cycle sequencer that computes a signed dot product of two vectors held in a local operand memory.
- It reuses the shared ALU (op codes ADD=3'b000, MUL=3'b001) rather than owning its own multiplier.
- It sits between the instruction decode stage, which issues start/base/length, and the ALU plus operand RAM.
- It owns the ALU inputs while busy and reports a single 32-bit result with a done pulse.

Parameters:
- DATA_W, 32: operand, ALU and result width.
- ADDR_W, 8: operand memory address width.
- LEN_W, 8: vector length field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- base_a  in  ADDR_W  address of element 0 of vector A; captured on start.
- base_b  in  ADDR_W  address of element 0 of vector B; captured on start.
- len  in  LEN_W  element count; captured on start; 0 is legal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  DATA_W  signed dot product; held until next accepted start.
- mem_rd  out  1  operand memory read strobe.
- mem_addr  out  ADDR_W  operand memory read address.
- mem_rdata  in  DATA_W  read data; valid exactly 1 cycle after mem_rd.
- alu_op  out  3  ALU op code.
- alu_a  out  DATA_W  ALU input 1.
- alu_b  out  DATA_W  ALU input 2.
- alu_out  in  DATA_W  ALU result; combinational from alu_op/alu_a/alu_b.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0, mem_rd=0, mem_addr=0.
  - alu_op=3'b000, alu_a=0, alu_b=0.
  - Internal acc, element counter, A/B address pointers and operand registers all cleared.
- FSM states: IDLE, FETCH_A, FETCH_B, MUL, ACC, FIN.
- IDLE:
  - ALU outputs are driven op=000 with a=b=0.
  - On start=1: capture base_a, base_b and len; clear acc.
  - Next state is FETCH_A if len!=0, otherwise FIN.
- FETCH_A: mem_rd=1, mem_addr=ptr_a. Next state FETCH_B.
- FETCH_B: mem_rd=1, mem_addr=ptr_b; register mem_rdata as opA. Next state MUL.
- MUL:
  - Register mem_rdata as opB.
  - Drive alu_op=001, alu_a=opA, alu_b=mem_rdata.
  - Register alu_out as prod. Next state ACC.
- ACC:
  - Drive alu_op=000, alu_a=acc, alu_b=prod.
  - acc<=alu_out; ptr_a, ptr_b incremented; counter incremented.
  - Next state is FIN if counter+1==len, otherwise FETCH_A.
- FIN: done=1 for this cycle only; result<=acc; busy=1. Next state IDLE.
- mem_rd is 0 in every state other than FETCH_A and FETCH_B. Outside MUL and ACC, ALU outputs are op=000 with a=b=0.
- Latency: with start accepted at cycle 0, done is asserted in cycle 4*len+1. For len=0, done is asserted in cycle 1 with result=0.
- Arithmetic:
  - Products and sums are two's complement, truncated to DATA_W, following the ALU's low-word truncation.
  - Overflow wraps silently; there is no saturation and no flag.
- Pointers wrap modulo 2^ADDR_W; 0xFF+1 gives 0x00 at the default width.
- A len value at maximum (2^LEN_W-1) must complete correctly; the counter is LEN_W bits wide.
- start while busy (including during FIN) is ignored; it is not queued.
- start in the same cycle as FIN's return to IDLE is not seen. The earliest restart is the cycle after done.
- result changes only in FIN. A new start does not clear result until that operation's FIN.
- Reset mid-operation: immediate return to IDLE with no done pulse; result=0.

Test Plan:
- A={1,2,3} at 0x10, B={4,5,6} at 0x20, len=3, start at cycle 0 -> done pulse at cycle 13 only, result=32, busy high cycles 1..13.
- A={-2,7}, B={3,-4}, len=2 -> result=0xFFFFFFDE (-34), done at cycle 9; alu_op sequence 001,000,001,000 in the MUL/ACC cycles.
- len=0, start -> done at cycle 1, result=0, mem_rd never asserted.
- base_a=0xFF, base_b=0x7F, len=2 -> mem_addr sequence 0xFF,0x7F,0x00,0x80. A={0x00010000,0x00010000}, B={0x00010000,1} -> result=0x00010000, showing the wrapped product 0 plus 0x10000.
- Second start pulsed at cycles 3 and 13 of a len=3 run -> both ignored, single done. Start at cycle 14 is accepted.
- rst_n low at cycle 6 of a len=3 run -> all outputs 0 asynchronously, no done. A new start after release completes normally.
